mfcc_mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the MFCC 16-bit coefficient/scratch register memory (65 words, single port, registered read, 7-bit address). It lets two MFCC stages, e.g. the power-spectrum writer and the mel-filter reader, share that one memory. It serialises their requests into single-cycle memory commands, returns read data with a fixed latency, and flags out-of-range addresses.

---
 rtl/mfcc_pkg.sv | 13 +
 rtl/mfcc_mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mfcc_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mfcc_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared constants and state encoding for the MFCC memory arbiter
package mfcc_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DEPTH  = 65;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mfcc_mem_arbiter_rr_arb2.sv
// rtl/mfcc_mem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mfcc_mem_arbiter.sv
// rtl/mfcc_mem_arbiter.sv - two-port round-robin sequencer for the MFCC scratch memory
module mfcc_mem_arbiter
    import mfcc_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              err_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,

    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              err_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,

    output logic              mem_write_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_t        state;
    logic              last_grant;

    logic              winner;
    logic              win_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oob;

    // Command stage: describes the transaction currently on the mem_* bus.
    logic              cmd_rd;
    logic              cmd_owner;
    logic              cmd_oob;

    // Pending-read stage: memory has registered the data, capture next edge.
    logic              pend_valid;
    logic              pend_owner;
    logic              pend_oob;

    rr_arb2 u_arb (
        .req        ({req_1, req_0}),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_valid)
    );

    // Route the winning requester's command fields and range-check its address.
    always_comb begin
        sel_we    = winner ? we_1    : we_0;
        sel_addr  = winner ? addr_1  : addr_0;
        sel_wdata = winner ? wdata_1 : wdata_0;
        sel_oob   = (int'(sel_addr) >= DEPTH);
    end

    // Arbitration FSM, command registers and read-return pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            gnt_0          <= 1'b0;
            gnt_1          <= 1'b0;
            err_0          <= 1'b0;
            err_1          <= 1'b0;
            rvalid_0       <= 1'b0;
            rvalid_1       <= 1'b0;
            rdata_0        <= '0;
            rdata_1        <= '0;
            mem_write_read <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
            cmd_rd         <= 1'b0;
            cmd_owner      <= 1'b0;
            cmd_oob        <= 1'b0;
            pend_valid     <= 1'b0;
            pend_owner     <= 1'b0;
            pend_oob       <= 1'b0;
        end else begin
            gnt_0          <= 1'b0;
            gnt_1          <= 1'b0;
            err_0          <= 1'b0;
            err_1          <= 1'b0;
            rvalid_0       <= 1'b0;
            rvalid_1       <= 1'b0;
            mem_write_read <= 1'b0;
            pend_valid     <= 1'b0;

            // Return stage runs independently of the FSM so it can overlap a new grant.
            if (pend_valid) begin
                if (pend_owner) begin
                    rvalid_1 <= 1'b1;
                    rdata_1  <= pend_oob ? '0 : mem_data_out;
                end else begin
                    rvalid_0 <= 1'b1;
                    rdata_0  <= pend_oob ? '0 : mem_data_out;
                end
            end

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state          <= GRANT;
                        last_grant     <= winner;
                        cmd_rd         <= ~sel_we;
                        cmd_owner      <= winner;
                        cmd_oob        <= sel_oob;
                        mem_write_read <= sel_we & ~sel_oob;
                        mem_address    <= sel_oob ? '0 : sel_addr;
                        if (sel_we && !sel_oob) begin
                            mem_data_in <= sel_wdata;
                        end
                        if (winner) begin
                            gnt_1 <= 1'b1;
                            err_1 <= sel_oob;
                        end else begin
                            gnt_0 <= 1'b1;
                            err_0 <= sel_oob;
                        end
                    end
                end
                GRANT: begin
                    // Memory executes the command at this edge; a read lands next cycle.
                    state <= IDLE;
                    if (cmd_rd) begin
                        pend_valid <= 1'b1;
                        pend_owner <= cmd_owner;
                        pend_oob   <= cmd_oob;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfcc_mem_arbiter.sv
// tb/tb_mfcc_mem_arbiter.sv - scoreboard bench for mfcc_mem_arbiter
module tb_mfcc_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_0, we_0, req_1, we_1;
    logic [6:0]  addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1;
    logic        gnt_0, err_0, rvalid_0, gnt_1, err_1, rvalid_1;
    logic [15:0] rdata_0, rdata_1;
    logic        mem_write_read;
    logic [6:0]  mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem     [0:127];
    logic [15:0] ref_mem [0:127];

    logic [15:0] exp_d0[$], exp_d1[$];
    int          exp_c0[$], exp_c1[$];

    bit          rec = 0;
    int          g_id[$], g_cyc[$], g_addr[$];
    int          mwr_cnt = 0;
    int          mwr_addr = -1;

    mfcc_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .err_0(err_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .err_1(err_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_write_read(mem_write_read), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_write_read) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid_0) begin
            if (exp_d0.size() == 0) chk("rvalid_0 unexpected", 1, 0);
            else begin
                chk("rdata_0", rdata_0, exp_d0.pop_front());
                chk("rvalid_0 cycle", cyc, exp_c0.pop_front());
            end
        end
        if (rvalid_1) begin
            if (exp_d1.size() == 0) chk("rvalid_1 unexpected", 1, 0);
            else begin
                chk("rdata_1", rdata_1, exp_d1.pop_front());
                chk("rvalid_1 cycle", cyc, exp_c1.pop_front());
            end
        end
        if (rvalid_0 || rvalid_1) chk("rvalid overlap", rvalid_0 & rvalid_1, 0);
        if (gnt_0 || gnt_1) chk("gnt overlap", gnt_0 & gnt_1, 0);
        if (mem_write_read) begin
            mwr_cnt++;
            mwr_addr = mem_address;
        end
        if (rec && (gnt_0 || gnt_1)) begin
            g_id.push_back(gnt_1 ? 1 : 0);
            g_cyc.push_back(cyc);
            g_addr.push_back(mem_address);
        end
    end

    task automatic txn(input int k, input logic we, input logic [6:0] a, input logic [15:0] d,
                       input logic exp_err, input logic drop);
        bit seen = 0;
        if (k == 0) begin req_0 = 1; we_0 = we; addr_0 = a; wdata_0 = d; end
        else        begin req_1 = 1; we_1 = we; addr_1 = a; wdata_1 = d; end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (k == 0) ? gnt_0 : gnt_1;
        end
        if (!seen) chk($sformatf("gnt_%0d timeout", k), 0, 1);
        else begin
            chk($sformatf("err_%0d", k), (k == 0) ? err_0 : err_1, exp_err);
            if (exp_err) begin
                chk("err mem_write_read", mem_write_read, 0);
                chk("err mem_address", mem_address, 0);
            end else if (we) begin
                chk("wr mem_write_read", mem_write_read, 1);
                chk("wr mem_address", mem_address, a);
                chk("wr mem_data_in", mem_data_in, d);
                ref_mem[a] = d;
            end else begin
                chk("rd mem_write_read", mem_write_read, 0);
                chk("rd mem_address", mem_address, a);
            end
            if (!we) begin
                if (k == 0) begin exp_d0.push_back(exp_err ? 16'h0 : ref_mem[a]); exp_c0.push_back(cyc + 2); end
                else        begin exp_d1.push_back(exp_err ? 16'h0 : ref_mem[a]); exp_c1.push_back(cyc + 2); end
            end
        end
        if (drop) begin
            if (k == 0) req_0 = 0; else req_1 = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (exp_d0.size() + exp_d1.size()) != 0; i++) @(negedge clk);
        chk("scoreboard drained", exp_d0.size() + exp_d1.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"}, {gnt_0, gnt_1, err_0, err_1}, 0);
        chk({tag, " rvalid"}, {rvalid_0, rvalid_1}, 0);
        chk({tag, " rdata"}, {rdata_0, rdata_1}, 0);
        chk({tag, " mem cmd"}, {mem_write_read, mem_address, mem_data_in}, 0);
    endtask

    initial begin
        int rel;
        rst_n = 0;
        req_0 = 0; we_0 = 0; addr_0 = 0; wdata_0 = 0;
        req_1 = 0; we_1 = 0; addr_1 = 0; wdata_1 = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1;
        @(negedge clk);

        // Single write/read and preload of addresses 3/4
        mwr_cnt = 0;
        txn(0, 1, 7'd10, 16'hA5C3, 0, 1);
        repeat (3) @(negedge clk);
        chk("write pulse count", mwr_cnt, 1);
        chk("write pulse addr", mwr_addr, 10);
        txn(0, 0, 7'd10, 16'h0, 0, 1);
        txn(1, 1, 7'd3, 16'h0003, 0, 1);
        txn(1, 1, 7'd4, 16'h0004, 0, 1);
        drain();

        // Reset mid-read: read in flight must never return
        txn(0, 0, 7'd3, 16'h0, 0, 1);
        void'(exp_d0.pop_back());
        void'(exp_c0.pop_back());
        rst_n = 0;
        #1;
        chk_all_zero("mid-read reset");
        @(negedge clk);
        rst_n = 1;
        rel = cyc;
        @(posedge clk); #1;
        req_0 = 1; we_0 = 0; addr_0 = 7'd4;
        @(posedge clk); #1;
        chk("gnt_0 after release", gnt_0, 1);
        chk("release grant edge", cyc, rel + 2);
        exp_d0.push_back(16'h0004); exp_c0.push_back(cyc + 2);
        req_0 = 0;
        drain();

        // Boundary addresses
        txn(0, 1, 7'd64, 16'hBEEF, 0, 1);
        txn(0, 0, 7'd64, 16'h0, 0, 1);
        mwr_cnt = 0;
        txn(0, 1, 7'd65, 16'hDEAD, 1, 1);
        repeat (3) @(negedge clk);
        chk("oob write pulse count", mwr_cnt, 0);
        txn(1, 0, 7'd127, 16'h0, 1, 1);
        drain();

        // Tie and round-robin with continuous dual requests
        g_id.delete(); g_cyc.delete(); g_addr.delete();
        rec = 1;
        fork
            begin
                txn(0, 0, 7'd3, 16'h0, 0, 0);
                txn(0, 0, 7'd3, 16'h0, 0, 0);
                txn(0, 0, 7'd3, 16'h0, 0, 1);
            end
            begin
                txn(1, 0, 7'd4, 16'h0, 0, 0);
                txn(1, 0, 7'd4, 16'h0, 0, 0);
                txn(1, 0, 7'd4, 16'h0, 0, 1);
            end
        join
        drain();
        rec = 0;
        chk("rr grant count", g_id.size(), 6);
        for (int i = 0; i < 6 && i < g_id.size(); i++) begin
            chk($sformatf("rr order %0d", i), g_id[i], i % 2);
            if (i > 0) chk($sformatf("rr spacing %0d", i), g_cyc[i] - g_cyc[i-1], 2);
        end

        // Overlap: read right after write to the same address, then a third grant
        fork
            begin
                txn(0, 1, 7'd20, 16'h1234, 0, 0);
                txn(0, 0, 7'd3, 16'h0, 0, 1);
            end
            txn(1, 0, 7'd20, 16'h0, 0, 1);
        join
        drain();

        // Back-to-back same requester
        g_id.delete(); g_cyc.delete(); g_addr.delete();
        rec = 1;
        txn(0, 0, 7'd10, 16'h0, 0, 0);
        txn(0, 0, 7'd3, 16'h0, 0, 1);
        repeat (4) @(negedge clk);
        rec = 0;
        drain();
        chk("b2b grant count", g_id.size(), 2);
        if (g_id.size() == 2) begin
            chk("b2b first addr", g_addr[0], 10);
            chk("b2b second addr", g_addr[1], 3);
            chk("b2b spacing", g_cyc[1] - g_cyc[0], 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
